// File: rtl/mem_resp_pkg.sv
// Shared types and default sizes for the block memory responder.
package mem_resp_pkg;

   localparam int BLOCK_W_DEF    = 128;
   localparam int ADDR_W_DEF     = 28;
   localparam int DEPTH_LOG2_DEF = 8;
   localparam int LATENCY_DEF    = 5;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   typedef enum logic {GNT_I, GNT_D} gnt_t;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous block RAM behind the responder; rdata holds between reads.
module mem_resp_array import mem_resp_pkg::*; #(
   parameter int BLOCK_W    = BLOCK_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [BLOCK_W-1:0]    wdata,
   output logic [BLOCK_W-1:0]    rdata
);

   logic [BLOCK_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
   logic [BLOCK_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) r_mem[idx] <= wdata;
         else    r_rdata    <= r_mem[idx];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/mem_block_responder.sv
// Shared main-memory responder arbitrating i-cache fills and d-cache fills/write-backs.
// Optional access counters are built when MEM_RESP_STATS_EN is defined.
//
// state | meaning
// IDLE  | arbitrate; grant latches address/data/op and issues the array read
// BUSY  | count down latency; at zero load readdata or commit the write
// DONE  | one cycle with busywait low for the granted port
module mem_block_responder import mem_resp_pkg::*; #(
   parameter int BLOCK_W    = BLOCK_W_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int LATENCY    = LATENCY_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_mem_read,
   input  logic [ADDR_W-1:0]  i_mem_address,
   output logic [BLOCK_W-1:0] i_mem_readdata,
   output logic               i_mem_busywait,
   input  logic               d_mem_read,
   input  logic               d_mem_write,
   input  logic [ADDR_W-1:0]  d_mem_address,
   input  logic [BLOCK_W-1:0] d_mem_writedata,
   output logic [BLOCK_W-1:0] d_mem_readdata,
   output logic               d_mem_busywait
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [31:0]        i_rd_count,
   output logic [31:0]        d_rd_count,
   output logic [31:0]        d_wr_count
`endif
);

   state_t                r_state, w_state_nxt;
   gnt_t                  r_gnt, r_last_gnt, w_sel;
   logic [3:0]            r_cnt;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [BLOCK_W-1:0]    r_wdata;
   logic                  r_op_wr;
   logic [BLOCK_W-1:0]    r_i_rdata, r_d_rdata;
   logic                  w_i_req, w_d_req, w_grant, w_complete;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic                  w_ram_en, w_ram_we;
   logic [DEPTH_LOG2-1:0] w_ram_idx;
   logic [BLOCK_W-1:0]    w_ram_rdata;

   assign w_i_req    = i_mem_read;
   assign w_d_req    = d_mem_read | d_mem_write;
   assign w_complete = (r_state == BUSY) && (r_cnt == 4'd0);

   always_comb begin
      w_grant = 1'b0;
      w_sel   = GNT_I;
      if (r_state == IDLE) begin
         if (w_d_req && w_i_req) begin
            w_grant = 1'b1;
            w_sel   = (r_last_gnt == GNT_I) ? GNT_D : GNT_I;
         end else if (w_d_req) begin
            w_grant = 1'b1;
            w_sel   = GNT_D;
         end else if (w_i_req) begin
            w_grant = 1'b1;
            w_sel   = GNT_I;
         end
      end
   end

   assign w_sel_addr = (w_sel == GNT_D) ? d_mem_address : i_mem_address;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant) w_state_nxt = BUSY;
         BUSY:    if (r_cnt == 4'd0) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt      <= 4'd0;
         r_gnt      <= GNT_I;
         r_last_gnt <= GNT_I;
         r_idx      <= '0;
         r_wdata    <= '0;
         r_op_wr    <= 1'b0;
         r_i_rdata  <= '0;
         r_d_rdata  <= '0;
      end else if (w_grant) begin
         r_gnt   <= w_sel;
         r_idx   <= w_sel_addr[DEPTH_LOG2-1:0];
         r_wdata <= d_mem_writedata;
         r_op_wr <= (w_sel == GNT_D) && d_mem_write;
         r_cnt   <= 4'(LATENCY - 1);
      end else if (r_state == BUSY) begin
         if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end else begin
            r_last_gnt <= r_gnt;
            if (!r_op_wr) begin
               if (r_gnt == GNT_I) r_i_rdata <= w_ram_rdata;
               else                r_d_rdata <= w_ram_rdata;
            end
         end
      end
   end

   // Reads are issued at grant so the RAM output is settled long before the
   // completion cycle; writes are only committed at completion.
   assign w_ram_en  = w_grant | (w_complete & r_op_wr);
   assign w_ram_we  = w_complete & r_op_wr;
   assign w_ram_idx = (r_state == IDLE) ? w_sel_addr[DEPTH_LOG2-1:0] : r_idx;

   mem_resp_array #(
      .BLOCK_W   (BLOCK_W),
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk  (clk),
      .en   (w_ram_en),
      .we   (w_ram_we),
      .idx  (w_ram_idx),
      .wdata(r_wdata),
      .rdata(w_ram_rdata)
   );

   assign i_mem_readdata = r_i_rdata;
   assign d_mem_readdata = r_d_rdata;
   assign i_mem_busywait = w_i_req & ~((r_state == DONE) && (r_gnt == GNT_I));
   assign d_mem_busywait = w_d_req & ~((r_state == DONE) && (r_gnt == GNT_D));

`ifdef MEM_RESP_STATS_EN
   logic [31:0] r_i_rd_count, r_d_rd_count, r_d_wr_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_i_rd_count <= '0;
         r_d_rd_count <= '0;
         r_d_wr_count <= '0;
      end else if (r_state == DONE) begin
         if (r_op_wr)              r_d_wr_count <= r_d_wr_count + 32'd1;
         else if (r_gnt == GNT_I)  r_i_rd_count <= r_i_rd_count + 32'd1;
         else                      r_d_rd_count <= r_d_rd_count + 32'd1;
      end
   end

   assign i_rd_count = r_i_rd_count;
   assign d_rd_count = r_d_rd_count;
   assign d_wr_count = r_d_wr_count;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed self-checking bench for mem_block_responder (default parameters).
module tb_mem_block_responder;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] PAT_3C = {16{8'h3C}};
   localparam logic [127:0] PAT_C3 = {16{8'hC3}};
   localparam logic [127:0] PAT_77 = {16{8'h77}};
   localparam logic [127:0] PAT_99 = {16{8'h99}};
   localparam logic [127:0] PAT_11 = {16{8'h11}};
   localparam logic [127:0] PAT_5A = {16{8'h5A}};

   logic         clk;
   logic         reset;
   logic         i_mem_read;
   logic [27:0]  i_mem_address;
   logic [127:0] i_mem_readdata;
   logic         i_mem_busywait;
   logic         d_mem_read;
   logic         d_mem_write;
   logic [27:0]  d_mem_address;
   logic [127:0] d_mem_writedata;
   logic [127:0] d_mem_readdata;
   logic         d_mem_busywait;
`ifdef MEM_RESP_STATS_EN
   logic [31:0]  i_rd_count, d_rd_count, d_wr_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mem_block_responder dut (
      .clk            (clk),
      .reset          (reset),
      .i_mem_read     (i_mem_read),
      .i_mem_address  (i_mem_address),
      .i_mem_readdata (i_mem_readdata),
      .i_mem_busywait (i_mem_busywait),
      .d_mem_read     (d_mem_read),
      .d_mem_write    (d_mem_write),
      .d_mem_address  (d_mem_address),
      .d_mem_writedata(d_mem_writedata),
      .d_mem_readdata (d_mem_readdata),
      .d_mem_busywait (d_mem_busywait)
`ifdef MEM_RESP_STATS_EN
      ,
      .i_rd_count     (i_rd_count),
      .d_rd_count     (d_rd_count),
      .d_wr_count     (d_wr_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // D-port access: counts busy cycles (bounded), then checks the port re-stalls
   // one cycle after DONE while the request is still held, then drops it.
   task automatic req_d(input logic rd, input logic wr, input logic [27:0] addr,
                        input logic [127:0] data, input bit scramble,
                        output int nbusy, output logic rehigh);
      @(negedge clk);
      d_mem_read = rd; d_mem_write = wr; d_mem_address = addr; d_mem_writedata = data;
      nbusy = 0;
      #1;
      while (d_mem_busywait && nbusy < 40) begin
         nbusy++;
         @(negedge clk);
         if (scramble && nbusy == 2) begin
            d_mem_address = ~addr; d_mem_writedata = ~data;
         end
         #1;
      end
      @(negedge clk);
      #1;
      rehigh = d_mem_busywait;
      d_mem_read = 1'b0; d_mem_write = 1'b0;
   endtask

   task automatic req_i(input logic [27:0] addr, output int nbusy, output logic rehigh);
      @(negedge clk);
      i_mem_read = 1'b1; i_mem_address = addr;
      nbusy = 0;
      #1;
      while (i_mem_busywait && nbusy < 40) begin
         nbusy++;
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      #1;
      rehigh = i_mem_busywait;
      i_mem_read = 1'b0;
   endtask

   // Both ports request together; each drops its request in its own DONE cycle.
   task automatic tie(input logic [27:0] ia, input logic [27:0] da,
                      output int ilow, output int dlow);
      @(negedge clk);
      i_mem_read = 1'b1; i_mem_address = ia;
      d_mem_read = 1'b1; d_mem_address = da;
      ilow = -1; dlow = -1;
      for (int k = 0; k < 40 && (ilow < 0 || dlow < 0); k++) begin
         #1;
         if (ilow < 0 && !i_mem_busywait) begin ilow = k; i_mem_read = 1'b0; end
         if (dlow < 0 && !d_mem_busywait) begin dlow = k; d_mem_read = 1'b0; end
         @(negedge clk);
      end
      i_mem_read = 1'b0; d_mem_read = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      i_mem_read = 1'b1;
      #1;
      n_checks++; if (i_mem_busywait !== 1'b1) begin n_fail++; $display("FAIL rst_i_busy got %b exp 1", i_mem_busywait); end
      n_checks++; if (d_mem_busywait !== 1'b0) begin n_fail++; $display("FAIL rst_d_busy got %b exp 0", d_mem_busywait); end
      n_checks++; if (i_mem_readdata !== '0) begin n_fail++; $display("FAIL rst_i_rdata got %h exp 0", i_mem_readdata); end
      n_checks++; if (d_mem_readdata !== '0) begin n_fail++; $display("FAIL rst_d_rdata got %h exp 0", d_mem_readdata); end
      i_mem_read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_d_write();
      int nb; logic rh;
      req_d(1'b0, 1'b1, 28'h10, PAT_A5, 1'b0, nb, rh);
      n_checks++; if (nb !== 6) begin n_fail++; $display("FAIL dwr_busy_cycles got %0d exp 6", nb); end
      n_checks++; if (rh !== 1'b1) begin n_fail++; $display("FAIL dwr_done_one_cycle got %b exp 1", rh); end
      n_checks++; if (d_mem_readdata !== '0) begin n_fail++; $display("FAIL dwr_d_rdata got %h exp 0", d_mem_readdata); end
   endtask

   task automatic test_i_read();
      int nb; logic rh;
      req_i(28'h10, nb, rh);
      n_checks++; if (nb !== 6) begin n_fail++; $display("FAIL ird_busy_cycles got %0d exp 6", nb); end
      n_checks++; if (rh !== 1'b1) begin n_fail++; $display("FAIL ird_done_one_cycle got %b exp 1", rh); end
      n_checks++; if (i_mem_readdata !== PAT_A5) begin n_fail++; $display("FAIL ird_data got %h exp %h", i_mem_readdata, PAT_A5); end
      n_checks++; if (d_mem_readdata !== '0) begin n_fail++; $display("FAIL ird_d_untouched got %h exp 0", d_mem_readdata); end
   endtask

   task automatic test_write_priority();
      int nb; logic rh;
      req_d(1'b1, 1'b1, 28'h20, PAT_3C, 1'b0, nb, rh);
      n_checks++; if (d_mem_readdata !== '0) begin n_fail++; $display("FAIL rdwr_is_write got %h exp 0", d_mem_readdata); end
      req_d(1'b1, 1'b0, 28'h20, '0, 1'b0, nb, rh);
      n_checks++; if (nb !== 6) begin n_fail++; $display("FAIL drd_busy_cycles got %0d exp 6", nb); end
      n_checks++; if (d_mem_readdata !== PAT_3C) begin n_fail++; $display("FAIL drd_data got %h exp %h", d_mem_readdata, PAT_3C); end
      n_checks++; if (i_mem_readdata !== PAT_A5) begin n_fail++; $display("FAIL drd_i_hold got %h exp %h", i_mem_readdata, PAT_A5); end
   endtask

   task automatic test_alias();
      int nb; logic rh;
      req_d(1'b0, 1'b1, 28'h110, PAT_C3, 1'b0, nb, rh);
      req_i(28'h010, nb, rh);
      n_checks++; if (i_mem_readdata !== PAT_C3) begin n_fail++; $display("FAIL alias_i got %h exp %h", i_mem_readdata, PAT_C3); end
      req_d(1'b1, 1'b0, 28'h210, '0, 1'b0, nb, rh);
      n_checks++; if (d_mem_readdata !== PAT_C3) begin n_fail++; $display("FAIL alias_d got %h exp %h", d_mem_readdata, PAT_C3); end
      req_d(1'b0, 1'b1, 28'h010, PAT_A5, 1'b0, nb, rh);
   endtask

   task automatic test_tie();
      int il, dl, nb; logic rh;
      pulse_reset();
      tie(28'h20, 28'h10, il, dl);
      n_checks++; if (dl !== 6) begin n_fail++; $display("FAIL tie1_d_low got %0d exp 6", dl); end
      n_checks++; if (il !== 13) begin n_fail++; $display("FAIL tie1_i_low got %0d exp 13", il); end
      n_checks++; if (d_mem_readdata !== PAT_A5) begin n_fail++; $display("FAIL tie1_d_data got %h exp %h", d_mem_readdata, PAT_A5); end
      n_checks++; if (i_mem_readdata !== PAT_3C) begin n_fail++; $display("FAIL tie1_i_data got %h exp %h", i_mem_readdata, PAT_3C); end
      req_d(1'b0, 1'b1, 28'h40, PAT_77, 1'b0, nb, rh);
      tie(28'h40, 28'h20, il, dl);
      n_checks++; if (il !== 6) begin n_fail++; $display("FAIL tie2_i_low got %0d exp 6", il); end
      n_checks++; if (dl !== 13) begin n_fail++; $display("FAIL tie2_d_low got %0d exp 13", dl); end
      n_checks++; if (i_mem_readdata !== PAT_77) begin n_fail++; $display("FAIL tie2_i_data got %h exp %h", i_mem_readdata, PAT_77); end
      n_checks++; if (d_mem_readdata !== PAT_3C) begin n_fail++; $display("FAIL tie2_d_data got %h exp %h", d_mem_readdata, PAT_3C); end
   endtask

   task automatic test_mid_service();
      int nb; logic rh;
      req_d(1'b1, 1'b0, 28'h10, '0, 1'b1, nb, rh);
      n_checks++; if (nb !== 6) begin n_fail++; $display("FAIL latch_busy got %0d exp 6", nb); end
      n_checks++; if (d_mem_readdata !== PAT_A5) begin n_fail++; $display("FAIL latch_addr got %h exp %h", d_mem_readdata, PAT_A5); end
      @(negedge clk);
      d_mem_write = 1'b1; d_mem_address = 28'h50; d_mem_writedata = PAT_99;
      repeat (2) @(negedge clk);
      d_mem_write = 1'b0;
      #1;
      n_checks++; if (d_mem_busywait !== 1'b0) begin n_fail++; $display("FAIL drop_busy got %b exp 0", d_mem_busywait); end
      repeat (10) @(negedge clk);
      req_i(28'h50, nb, rh);
      n_checks++; if (i_mem_readdata !== PAT_99) begin n_fail++; $display("FAIL drop_write_done got %h exp %h", i_mem_readdata, PAT_99); end
   endtask

   task automatic test_reset_mid_busy();
      int nb; logic rh;
      req_d(1'b0, 1'b1, 28'h30, PAT_11, 1'b0, nb, rh);
      @(negedge clk);
      d_mem_write = 1'b1; d_mem_address = 28'h30; d_mem_writedata = PAT_5A;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++; if (d_mem_readdata !== '0) begin n_fail++; $display("FAIL rstbusy_d_rdata got %h exp 0", d_mem_readdata); end
      n_checks++; if (i_mem_readdata !== '0) begin n_fail++; $display("FAIL rstbusy_i_rdata got %h exp 0", i_mem_readdata); end
      n_checks++; if (d_mem_busywait !== 1'b1) begin n_fail++; $display("FAIL rstbusy_d_busy got %b exp 1", d_mem_busywait); end
      d_mem_write = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      req_d(1'b1, 1'b0, 28'h30, '0, 1'b0, nb, rh);
      n_checks++; if (d_mem_readdata !== PAT_11) begin n_fail++; $display("FAIL rstbusy_no_write got %h exp %h", d_mem_readdata, PAT_11); end
      req_d(1'b0, 1'b1, 28'h30, PAT_5A, 1'b0, nb, rh);
      n_checks++; if (nb !== 6) begin n_fail++; $display("FAIL rstbusy_rereq_busy got %0d exp 6", nb); end
      req_i(28'h30, nb, rh);
      n_checks++; if (i_mem_readdata !== PAT_5A) begin n_fail++; $display("FAIL rstbusy_rereq_data got %h exp %h", i_mem_readdata, PAT_5A); end
   endtask

`ifdef MEM_RESP_STATS_EN
   task automatic test_stats();
      int nb; logic rh;
      pulse_reset();
      #1;
      n_checks++; if (d_wr_count !== 32'd0) begin n_fail++; $display("FAIL stats_rst_wr got %0d exp 0", d_wr_count); end
      for (int k = 0; k < 3; k++) req_i(28'(k), nb, rh);
      for (int k = 0; k < 2; k++) req_d(1'b1, 1'b0, 28'(k), '0, 1'b0, nb, rh);
      for (int k = 0; k < 4; k++) req_d(k == 0, 1'b1, 28'(8 + k), PAT_11, 1'b0, nb, rh);
      n_checks++; if (i_rd_count !== 32'd3) begin n_fail++; $display("FAIL stats_i_rd got %0d exp 3", i_rd_count); end
      n_checks++; if (d_rd_count !== 32'd2) begin n_fail++; $display("FAIL stats_d_rd got %0d exp 2", d_rd_count); end
      n_checks++; if (d_wr_count !== 32'd4) begin n_fail++; $display("FAIL stats_d_wr got %0d exp 4", d_wr_count); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++; if ({i_rd_count, d_rd_count, d_wr_count} !== 96'd0) begin n_fail++; $display("FAIL stats_clear got %0d/%0d/%0d exp 0/0/0", i_rd_count, d_rd_count, d_wr_count); end
      @(negedge clk);
      reset = 1'b1;
   endtask
`endif

   initial begin
      reset = 1'b0;
      i_mem_read = 1'b0; i_mem_address = '0;
      d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = '0; d_mem_writedata = '0;
      test_reset();
      test_d_write();
      test_i_read();
      test_write_priority();
      test_alias();
      test_tie();
      test_mid_service();
      test_reset_mid_busy();
`ifdef MEM_RESP_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
